imm_narrow: RTL
===============

# imm_narrow

Streaming narrowing unit for the datapath: it is the inverse of the 21→32-bit immediate sign extender. It takes 32-bit signed values, range-checks them against the 21-bit signed immediate field, and emits 21-bit results, saturating or wrapping on overflow. It sits between the ALU/result path and the instruction/immediate packer. Values arrive and leave through valid/ready handshakes, with a 2-entry output buffer, per-beat overflow flags and overflow statistics.

## Interface
- IN_W, 32, input width (signed)
- OUT_W, 21, output width (signed), OUT_W < IN_W
- SAT, 1, 1 = saturate on overflow, 0 = truncate (keep low OUT_W bits)
- CNT_W, 16, overflow counter width

- clk  input  1  sole clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  upstream beat valid
- in_ready  output  1  unit can accept a beat
- in_data  input  IN_W  signed value to narrow
- out_valid  output  1  buffered result available
- out_ready  input  1  downstream accepts result
- out_data  output  OUT_W  narrowed value
- out_ovf  output  1  overflow flag travelling with out_data
- ovf_sticky  output  1  set on any accepted overflowing beat
- ovf_count  output  CNT_W  number of accepted overflowing beats, saturating
- ovf_clr  input  1  synchronous clear of ovf_sticky and ovf_count

## Operation
- Accept when in_valid && in_ready. Pop when out_valid && out_ready.
- Fit test: in_data[IN_W-1:OUT_W-1] are all equal bits. If the value fits, the result is in_data[OUT_W-1:0] and ovf=0.
- Overflow with SAT=1: if in_data[IN_W-1]=0 the result is the max positive value, 0x0FFFFF. Otherwise it is the min negative value, 0x100000. ovf=1.
- Overflow with SAT=0: the result is in_data[OUT_W-1:0]. ovf=1.
- Result and ovf are computed combinationally at accept and written as one {ovf, data} entry into a 2-entry FIFO.
- in_ready = (occupancy < 2), derived from registered occupancy only. It has no combinational path from out_ready.
- out_valid = (occupancy > 0). out_data/out_ovf present the head entry and stay stable while out_valid && !out_ready.
- Occupancy rules:
  - Push only: +1.
  - Pop only: −1.
  - Push and pop in the same cycle (occupancy 1): stays 1, order preserved.
  - Occupancy 2: push blocked; a pop frees a slot for the next cycle.
- Counters:
  - On an accepted overflowing beat: ovf_sticky←1, and ovf_count←ovf_count+1 unless already all-ones.
  - ovf_clr alone: sticky←0, count←0.
  - ovf_clr together with an accepted overflowing beat: sticky←1, count←1 (the new event wins over the clear).

## Timing
- Reset (rst_n low, asynchronous): occupancy 0, out_valid 0, out_data 0, out_ovf 0, ovf_sticky 0, ovf_count 0, in_ready 1.
- Reset mid-operation discards all buffered entries immediately; there is no pending output after release.
- Latency: a beat accepted at edge N is visible on out_* after edge N, i.e. 1 cycle.
- Throughput: 1 beat/cycle while out_ready is held high.
- ovf_sticky and ovf_count update on the same edge that accepts the beat. They are not tied to the beat being popped.

## Structure
- Package imm_pkg holds:
  - IN_W and OUT_W defaults.
  - Localparams IMM_MAX (0x0FFFFF) and IMM_MIN (0x100000) derived from OUT_W.
  - Entry type {ovf, data[OUT_W-1:0]}.
  - Package is shared with the sign extender and the immediate packer.
- Sub-module imm_narrow_fifo2: generic 2-entry synchronous FIFO with push/pop/full/empty and an async active-low reset.
- imm_narrow itself contains the range check, saturation mux and counter logic.

## Test plan
- Round-trip fits: drive 0x0006A300 then 0xFFFEA300, with out_ready=1.
  - Required: out_data 0x06A300 then 0x1EA300 (bit patterns 001101010001100000000 and 111101010001100000000), out_ovf=0, ovf_count=0.
- Boundaries with SAT=1:
  - 0x000FFFFF → 0x0FFFFF, ovf=0.
  - 0xFFF00000 → 0x100000, ovf=0.
  - 0x00100000 → 0x0FFFFF, ovf=1.
  - 0xFFEFFFFF → 0x100000, ovf=1.
  - Final state: ovf_count=2, ovf_sticky=1.
- SAT=0 wrap: 0x00100000 → 0x100000 with ovf=1, and 0x12345678 → 0x145678 with ovf=1.
- Backpressure: hold out_ready=0 and offer 3 beats.
  - Required: 2 accepted, in_ready=0 on the 3rd, out_data stable.
  - Then raise out_ready: beats emerge in order, and the 3rd is accepted the cycle after the first pop.
- Clear collision: ovf_count=5, assert ovf_clr in the same cycle as accepting 0x7FFFFFFF → next cycle count=1, sticky=1. ovf_clr alone → count=0, sticky=0.
- Reset mid-stream: occupancy 2, pull rst_n low between edges.
  - Required: out_valid=0 and ovf_count=0 immediately, in_ready=1.
  - After release, no stale beat emerges.

Source files
------------

// File: rtl/imm_narrow_pkg.sv
// imm_pkg: shared definitions for the 21-bit immediate datapath.
// Used by the immediate narrower, the sign extender and the immediate packer.
//   IMM_IN_W / IMM_OUT_W : default wide and narrow widths
//   IMM_MAX / IMM_MIN    : saturation limits of the narrow signed field
//   imm_entry_t          : {ovf, data} record carried through the narrower
package imm_pkg;

    localparam int IMM_IN_W  = 32;
    localparam int IMM_OUT_W = 21;

    localparam logic [IMM_OUT_W-1:0] IMM_MAX = {1'b0, {(IMM_OUT_W-1){1'b1}}};
    localparam logic [IMM_OUT_W-1:0] IMM_MIN = {1'b1, {(IMM_OUT_W-1){1'b0}}};

    typedef struct packed {
        logic                 ovf;
        logic [IMM_OUT_W-1:0] data;
    } imm_entry_t;

endpackage

// File: rtl/imm_narrow_fifo2.sv
// imm_narrow_fifo2: generic 2-entry synchronous FIFO.
//   clk, rst_n : clock, asynchronous active-low reset (clears storage too)
//   push/wdata : write when push && !full
//   pop/rdata  : rdata is the head entry; advance when pop && !empty
//   full/empty : derived from registered occupancy only
module imm_narrow_fifo2 #(
    parameter int W = 22
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count;
    logic         do_push;
    logic         do_pop;

    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            // Simultaneous push and pop leaves occupancy unchanged.
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/imm_narrow.sv
// imm_narrow: narrows signed IN_W-bit values to the OUT_W-bit immediate field.
// Overflowing values saturate (SAT=1) or wrap to the low OUT_W bits (SAT=0);
// either way the beat is flagged. Results pass through a 2-entry buffer.
//   in_valid/in_ready/in_data     : upstream handshake, wide signed value
//   out_valid/out_ready/out_data  : downstream handshake, narrow result
//   out_ovf                       : overflow flag of the head result
//   ovf_sticky/ovf_count/ovf_clr  : overflow statistics and their clear
module imm_narrow
    import imm_pkg::*;
#(
    parameter int IN_W  = IMM_IN_W,
    parameter int OUT_W = IMM_OUT_W,
    parameter bit SAT   = 1'b1,
    parameter int CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [IN_W-1:0]  in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] out_data,
    output logic                    out_ovf,
    output logic                    ovf_sticky,
    output logic [CNT_W-1:0]        ovf_count,
    input  logic                    ovf_clr
);

    // Returns {ovf, data}. The value fits when every bit from the sign bit down
    // to the narrow sign position agrees.
    function automatic logic [OUT_W:0] narrow(input logic signed [IN_W-1:0] v);
        logic [IN_W-OUT_W:0] upper;
        logic                fits;
        logic [OUT_W-1:0]    d;
        upper = v[IN_W-1:OUT_W-1];
        fits  = (&upper) || !(|upper);
        d     = v[OUT_W-1:0];
        if (!fits && SAT) begin
            d = v[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                          : {1'b0, {(OUT_W-1){1'b1}}};
        end
        return {!fits, d};
    endfunction

    logic                    vld_p0;
    logic [OUT_W:0]          res_p0;
    logic                    ovf_p0;
    logic                    pop;
    logic                    full;
    logic                    empty;
    logic [OUT_W:0]          head_p1;

    // ---- stage p0: accept and narrow combinationally ----
    assign vld_p0 = in_valid && in_ready;
    assign res_p0 = narrow(in_data);
    assign ovf_p0 = res_p0[OUT_W];

    assign in_ready = !full;
    assign pop      = out_valid && out_ready;

    imm_narrow_fifo2 #(
        .W (OUT_W + 1)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (vld_p0),
        .wdata (res_p0),
        .pop   (pop),
        .rdata (head_p1),
        .full  (full),
        .empty (empty)
    );

    // ---- stage p1: buffered head entry ----
    assign out_valid = !empty;
    assign out_ovf   = head_p1[OUT_W];
    assign out_data  = head_p1[OUT_W-1:0];

    // Statistics follow acceptance, not popping. A new overflow on the same
    // edge as a clear wins: the count restarts at one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_sticky <= 1'b0;
            ovf_count  <= '0;
        end else if (vld_p0 && ovf_p0) begin
            ovf_sticky <= 1'b1;
            if (ovf_clr) begin
                ovf_count <= {{(CNT_W-1){1'b0}}, 1'b1};
            end else if (ovf_count != {CNT_W{1'b1}}) begin
                ovf_count <= ovf_count + 1'b1;
            end
        end else if (ovf_clr) begin
            ovf_sticky <= 1'b0;
            ovf_count  <= '0;
        end
    end

endmodule
